dsp_uart: RTL and testbench

Output stage for the OUT instruction. Samples the low byte of the data bus whenever the controller asserts `dsp_in_en` and queues it in a small FIFO. Drains the FIFO as 8N1 serial frames (optional even parity) on a single `tx` line. Sits directly downstream of the controller's `dsp_in_en` strobe and beside memory/register-file on the shared 16-bit bus.

---
 rtl/tiny16_defs.sv | 15 +
 rtl/dsp_fifo.sv | 60 ++++++
 rtl/dsp_uart.sv | 137 +++++++++++++
 tb/tb_dsp_uart.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/tiny16_defs.sv
// Shared definitions for the tiny16 output stage: serializer state encoding
// and the stored data width.
package tiny16_defs;

    localparam int DSP_DATA_W = 8;

    typedef enum logic [2:0] {
        DSP_IDLE   = 3'd0,
        DSP_START  = 3'd1,
        DSP_DATA   = 3'd2,
        DSP_PARITY = 3'd3,
        DSP_STOP   = 3'd4
    } dsp_state_t;

endpackage

// File: rtl/dsp_fifo.sv
// Byte queue between the OUT strobe and the serializer. Drops pushes while
// full unless a pop frees the slot on the same edge; overflow is sticky.
module dsp_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (push && !do_push) overflow <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; an entry is only read while
    // count marks it valid, so reset only has to clear pointers and count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/dsp_uart.sv
// OUT-instruction serial output: queues bus low bytes and sends 8N1 frames,
// or 8E1 frames when DSP_UART_PARITY_EN is defined.
module dsp_uart
    import tiny16_defs::*;
#(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dsp_in_en,
    input  logic [15:0] in,
    output logic        tx,
    output logic        full,
    output logic        idle,
    output logic        overflow
);

    localparam int BAUD_W = $clog2(CLK_DIV);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    dsp_state_t            state;
    dsp_state_t            next_state;
    logic [BAUD_W-1:0]     baud;
    logic [BAUD_W-1:0]     baud_next;
    logic [2:0]            bit_cnt;
    logic [2:0]            bit_next;
    logic [DSP_DATA_W-1:0] shift;
    logic [DSP_DATA_W-1:0] shift_next;
    logic                  tx_next;
    logic                  pop;
    logic                  tc;
    logic                  empty;
    logic [DSP_DATA_W-1:0] head;
    logic [CNT_W-1:0]      count;
    logic                  unused_hi;
`ifdef DSP_UART_PARITY_EN
    logic                  par;
`endif

    assign unused_hi = ^in[15:8];

    dsp_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DSP_DATA_W)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (dsp_in_en),
        .pop      (pop),
        .din      (in[DSP_DATA_W-1:0]),
        .dout     (head),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .overflow (overflow)
    );

    assign tc   = (baud == BAUD_W'(CLK_DIV - 1));
    assign idle = (count == '0) && (state == DSP_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= DSP_IDLE;
        else      state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DSP_IDLE:  if (!empty) next_state = DSP_START;
            DSP_START: if (tc) next_state = DSP_DATA;
`ifdef DSP_UART_PARITY_EN
            DSP_DATA:   if (tc && bit_cnt == 3'd7) next_state = DSP_PARITY;
            DSP_PARITY: if (tc) next_state = DSP_STOP;
`else
            DSP_DATA:  if (tc && bit_cnt == 3'd7) next_state = DSP_STOP;
`endif
            DSP_STOP:  if (tc) next_state = empty ? DSP_IDLE : DSP_START;
            default:   next_state = DSP_IDLE;
        endcase
    end

    // tx is computed from the next state so the registered line changes on
    // the same edge as the state it belongs to.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        pop        = 1'b0;
        shift_next = shift;
        bit_next   = bit_cnt;
        baud_next  = (state == DSP_IDLE || tc) ? '0 : baud + BAUD_W'(1);
        case (state)
            DSP_IDLE: if (!empty) pop = 1'b1;
            DSP_DATA: if (tc) begin
                shift_next = shift >> 1;
                bit_next   = bit_cnt + 3'd1;
            end
            DSP_STOP: if (tc && !empty) pop = 1'b1;
            default: ;
        endcase
        if (pop) begin
            shift_next = head;
            bit_next   = 3'd0;
            baud_next  = '0;
        end
        case (next_state)
            DSP_START:  tx_next = 1'b0;
            DSP_DATA:   tx_next = shift_next[0];
`ifdef DSP_UART_PARITY_EN
            DSP_PARITY: tx_next = par;
`endif
            default:    tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud    <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            baud    <= baud_next;
            bit_cnt <= bit_next;
            shift   <= shift_next;
            tx      <= tx_next;
        end
    end

`ifdef DSP_UART_PARITY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     par <= 1'b0;
        else if (pop) par <= ^head;
    end
`endif

endmodule

// File: tb/tb_dsp_uart.sv
// Directed bench for dsp_uart with CLK_DIV=4, FIFO_DEPTH=8; frame shape follows
// DSP_UART_PARITY_EN when it is defined for the build.
module tb_dsp_uart;

    localparam int CLK_DIV    = 4;
    localparam int FIFO_DEPTH = 8;
`ifdef DSP_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        dsp_in_en;
    logic [15:0] in;
    logic        tx;
    logic        full;
    logic        idle;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    dsp_uart #(
        .CLK_DIV    (CLK_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dsp_in_en (dsp_in_en),
        .in        (in),
        .tx        (tx),
        .full      (full),
        .idle      (idle),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] v);
        dsp_in_en = 1'b1;
        in        = v;
        next_cycle();
        dsp_in_en = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) next_cycle();
        rst = 1'b1;
        next_cycle();
    endtask

    // Line levels of one frame, index 0 = start bit.
    function automatic logic [10:0] frame_bits(input logic [7:0] b);
        logic [10:0] f;
        f      = '1;
        f[0]   = 1'b0;
        f[8:1] = b;
`ifdef DSP_UART_PARITY_EN
        f[9]   = ^b;
`endif
        return f;
    endfunction

    // Called at the sample where the start bit has just appeared (minus skip);
    // returns at the first sample after the frame (minus drop).
    task automatic check_frame(input logic [7:0] b, input string tag, input int skip, input int drop);
        logic [10:0] f;
        f = frame_bits(b);
        for (int k = skip; k < FRAME - drop; k++) begin
            check($sformatf("%s bit%0d cyc%0d", tag, k / CLK_DIV, k), tx, f[k / CLK_DIV]);
            next_cycle();
        end
    endtask

    initial begin
        int bad;
        rst       = 1'b0;
        dsp_in_en = 1'b0;
        in        = '0;
        #1;
        repeat (3) next_cycle();
        rst = 1'b1;
        next_cycle();
        check("reset tx", tx, 1);
        check("reset full", full, 0);
        check("reset idle", idle, 1);
        check("reset overflow", overflow, 0);

        // Single byte, exact cycle alignment.
        push(16'h0041);
        check("t1 idle after push", idle, 0);
        check("t1 tx before start", tx, 1);
        next_cycle();
        check_frame(8'h41, "t1", 0, 0);
        check("t1 idle end", idle, 1);
        check("t1 tx end", tx, 1);

        // Back-to-back frames, upper byte ignored.
        push(16'h1255);
        push(16'h12AA);
        check_frame(8'h55, "t2a", 0, 0);
        check_frame(8'hAA, "t2b", 0, 0);
        check("t2 idle end", idle, 1);

        // Ten pushes: first pops at once, ninth fills, tenth is dropped.
        for (int i = 0; i < 10; i++) begin
            push(16'hA530 + 16'(i));
            if (i == 7) check("t3 full after 8", full, 0);
            if (i == 8) begin
                check("t3 full after 9", full, 1);
                check("t3 overflow after 9", overflow, 0);
            end
            if (i == 9) begin
                check("t3 overflow after 10", overflow, 1);
                check("t3 full after 10", full, 1);
            end
        end
        check_frame(8'h30, "t3 f0", 8, 0);
        for (int i = 1; i < 9; i++) check_frame(8'h30 + 8'(i), $sformatf("t3 f%0d", i), 0, 0);
        check("t3 idle end", idle, 1);
        check("t3 overflow sticky", overflow, 1);
        check("t3 full end", full, 0);

        // Push while full on the STOP terminal edge is accepted.
        do_reset();
        check("t4 overflow cleared", overflow, 0);
        for (int i = 0; i < 9; i++) push(16'h0060 + 16'(i));
        check("t4 full", full, 1);
        check_frame(8'h60, "t4 f0", 7, 1);
        check("t4 last stop sample", tx, 1);
        dsp_in_en = 1'b1;
        in        = 16'h77C3;
        next_cycle();
        dsp_in_en = 1'b0;
        check("t4 full kept", full, 1);
        check("t4 no overflow", overflow, 0);
        check("t4 next start", tx, 0);
        for (int i = 1; i < 9; i++) check_frame(8'h60 + 8'(i), $sformatf("t4 f%0d", i), 0, 0);
        check_frame(8'hC3, "t4 fC3", 0, 0);
        check("t4 idle end", idle, 1);
        check("t4 overflow end", overflow, 0);

        // Asynchronous reset in the middle of the DATA bits.
        push(16'h0000);
        push(16'h0000);
        push(16'h0000);
        repeat (10) next_cycle();
        check("t5 in data", tx, 0);
        rst = 1'b0;
        #1;
        check("t5 tx on reset", tx, 1);
        check("t5 idle on reset", idle, 1);
        check("t5 full on reset", full, 0);
        repeat (2) next_cycle();
        rst = 1'b1;
        bad = 0;
        repeat (2 * FRAME) begin
            next_cycle();
            if (tx !== 1'b1 || idle !== 1'b1) bad++;
        end
        check("t5 quiet after reset", bad, 0);

        // Parity vectors: 0x07 -> parity 1, 0x03 -> parity 0 when compiled in.
        push(16'h0007);
        next_cycle();
        check_frame(8'h07, "t6 x07", 0, 0);
        check("t6 idle after x07", idle, 1);
        push(16'h0003);
        next_cycle();
        check_frame(8'h03, "t6 x03", 0, 0);
        check("t6 idle after x03", idle, 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
